// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: packs a little-endian byte stream into 32-bit words,
// writes them through a single port and holds the CPU until the image is complete.
module imem_loader #(
   parameter int ADDR_W = 5,
   parameter int DEPTH  = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W:0]   num_words,
   input  logic              in_valid,
   input  logic [7:0]        in_byte,
   output logic              in_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RECV  = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [ADDR_W:0] L_DEPTH = (ADDR_W+1)'(DEPTH);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W:0]   r_num_words;
   logic [ADDR_W:0]   r_word_count;
   logic [ADDR_W-1:0] r_widx;
   logic [1:0]        r_bidx;
   logic [23:0]       r_asm;
   logic [31:0]       r_wdata;
   logic [ADDR_W-1:0] r_waddr;
   logic              r_error;
   logic              r_in_ready;
   logic              r_we;
   logic              r_cpu_hold;
   logic              r_done;
   logic              w_in_ready_nxt;
   logic              w_we_nxt;
   logic              w_cpu_hold_nxt;
   logic              w_done_nxt;
   logic              w_accept;
   logic              w_bad_num;
   logic [ADDR_W:0]   w_count_inc;

   assign w_accept    = in_valid & r_in_ready;
   assign w_bad_num   = (num_words > L_DEPTH);
   assign w_count_inc = r_word_count + (ADDR_W+1)'(1'b1);

   // State register; control outputs are registered from the next-state decode
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b0;
         r_we       <= 1'b0;
         r_cpu_hold <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= w_in_ready_nxt;
         r_we       <= w_we_nxt;
         r_cpu_hold <= w_cpu_hold_nxt;
         r_done     <= w_done_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if ((num_words == {(ADDR_W+1){1'b0}}) || w_bad_num) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_RECV;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_RECV: begin
            if (w_accept && (r_bidx == 2'd3)) begin
               w_state_nxt = S_WRITE;
            end else begin
               w_state_nxt = S_RECV;
            end
         end
         S_WRITE: begin
            if (w_count_inc == r_num_words) begin
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_RECV;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode of the upcoming state
   always_comb begin
      w_in_ready_nxt = 1'b0;
      w_we_nxt       = 1'b0;
      w_cpu_hold_nxt = 1'b0;
      w_done_nxt     = 1'b0;
      case (w_state_nxt)
         S_RECV: begin
            w_in_ready_nxt = 1'b1;
            w_cpu_hold_nxt = 1'b1;
         end
         S_WRITE: begin
            w_we_nxt       = 1'b1;
            w_cpu_hold_nxt = 1'b1;
         end
         S_DONE:  w_done_nxt = 1'b1;
         default: w_done_nxt = 1'b0;
      endcase
   end

   // Datapath: byte packing, write word/address capture, counters and sticky error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_num_words  <= {(ADDR_W+1){1'b0}};
         r_word_count <= {(ADDR_W+1){1'b0}};
         r_widx       <= {ADDR_W{1'b0}};
         r_bidx       <= 2'd0;
         r_asm        <= 24'd0;
         r_wdata      <= 32'd0;
         r_waddr      <= {ADDR_W{1'b0}};
         r_error      <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_num_words  <= num_words;
                  r_error      <= w_bad_num;
                  r_word_count <= {(ADDR_W+1){1'b0}};
                  r_widx       <= {ADDR_W{1'b0}};
                  r_bidx       <= 2'd0;
               end
            end
            S_RECV: begin
               if (w_accept) begin
                  r_bidx <= r_bidx + 2'd1;
                  case (r_bidx)
                     2'd0:    r_asm[7:0]   <= in_byte;
                     2'd1:    r_asm[15:8]  <= in_byte;
                     2'd2:    r_asm[23:16] <= in_byte;
                     default: begin
                        // The write-port registers change only when a full word is ready
                        r_wdata <= {in_byte, r_asm};
                        r_waddr <= r_widx;
                     end
                  endcase
               end
            end
            S_WRITE: begin
               r_widx       <= r_widx + ADDR_W'(1'b1);
               r_word_count <= w_count_inc;
            end
            default: begin
               r_bidx <= 2'd0;
            end
         endcase
      end
   end

   assign in_ready   = r_in_ready;
   assign imem_we    = r_we;
   assign imem_waddr = r_waddr;
   assign imem_wdata = r_wdata;
   assign cpu_hold   = r_cpu_hold;
   assign done       = r_done;
   assign error      = r_error;
   assign word_count = r_word_count;

endmodule
